// File: rtl/sram_adapter_pkg.sv
// rtl/sram_adapter_pkg.sv - shared widths, depths and FSM states for the SRAM request adapter
package sram_adapter_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 64;
  localparam int BE_W      = 8;
  localparam int ID_W      = 4;
  localparam int RSP_DEPTH = 3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - small in-order response FIFO holding {read data, tag}
module sram_rsp_fifo
  import sram_adapter_pkg::*;
#(
  parameter int DEPTH = RSP_DEPTH,
  parameter int WIDTH = DATA_W + ID_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only allowed when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_adapter.sv
// rtl/sram_req_adapter.sv - clears the SRAM after reset, then maps valid/ready requests onto a single-port SRAM
module sram_req_adapter
  import sram_adapter_pkg::*;
#(
  parameter int ADDR_W = sram_adapter_pkg::ADDR_W,
  parameter int DATA_W = sram_adapter_pkg::DATA_W,
  parameter int ID_W   = sram_adapter_pkg::ID_W
) (
  input  logic              Clk_CI,
  input  logic              Rst_RI,
  input  logic              ReqValid_SI,
  output logic              ReqReady_SO,
  input  logic              ReqWe_SI,
  input  logic [BE_W-1:0]   ReqBe_SI,
  input  logic [ADDR_W-1:0] ReqAddr_DI,
  input  logic [DATA_W-1:0] ReqWdata_DI,
  input  logic [ID_W-1:0]   ReqId_DI,
  output logic              RspValid_SO,
  input  logic              RspReady_SI,
  output logic [DATA_W-1:0] RspRdata_DO,
  output logic [ID_W-1:0]   RspId_DO,
  output logic              InitDone_SO,
  output logic              SramCSel_SO,
  output logic              SramWrEn_SO,
  output logic [BE_W-1:0]   SramBEn_SO,
  output logic [ADDR_W-1:0] SramAddr_DO,
  output logic [DATA_W-1:0] SramWrData_DO,
  input  logic [DATA_W-1:0] SramRdData_DI
);

  localparam int RSP_W = DATA_W + ID_W;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rd_pend_q;
  logic [ID_W-1:0]   rd_id_q;

  logic              req_ready;
  logic              accept;
  logic              rd_accept;
  logic              rsp_valid;
  logic              rsp_pop;
  logic [RSP_W-1:0]  fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;

  // Credit check counts the read still in flight to the SRAM, so the FIFO can never overflow.
  always_comb begin
    req_ready = 1'b0;
    if (!Rst_RI && state_q == RUN &&
        (int'(fifo_count) + int'(rd_pend_q) < RSP_DEPTH)) begin
      req_ready = 1'b1;
    end
  end

  assign ReqReady_SO = req_ready;
  assign accept      = ReqValid_SI && req_ready;
  assign rd_accept   = accept && !ReqWe_SI;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    SramCSel_SO   = 1'b0;
    SramWrEn_SO   = 1'b0;
    SramBEn_SO    = {BE_W{1'b1}};
    SramAddr_DO   = '0;
    SramWrData_DO = '0;
    if (!Rst_RI) begin
      if (state_q == INIT) begin
        SramCSel_SO = 1'b1;
        SramWrEn_SO = 1'b1;
        SramBEn_SO  = '0;
        SramAddr_DO = clr_cnt_q;
      end else if (accept) begin
        SramCSel_SO   = 1'b1;
        SramWrEn_SO   = ReqWe_SI;
        SramBEn_SO    = ~ReqBe_SI;
        SramAddr_DO   = ReqAddr_DI;
        SramWrData_DO = ReqWdata_DI;
      end
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rd_pend_q <= rd_accept;
      if (rd_accept) begin
        rd_id_q <= ReqId_DI;
      end
    end
  end

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RSP_W),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .Clk_CI    (Clk_CI),
    .Rst_RI    (Rst_RI),
    .push      (rd_pend_q),
    .push_data ({SramRdData_DI, rd_id_q}),
    .pop       (rsp_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Outputs are forced quiet during the reset cycle itself, before registers clear.
  assign rsp_valid   = !Rst_RI && !fifo_empty;
  assign rsp_pop     = rsp_valid && RspReady_SI;
  assign RspValid_SO = rsp_valid;
  assign RspRdata_DO = Rst_RI ? '0 : fifo_head[RSP_W-1:ID_W];
  assign RspId_DO    = Rst_RI ? '0 : fifo_head[ID_W-1:0];
  assign InitDone_SO = !Rst_RI && (state_q == RUN);

endmodule

// File: tb/tb_sram_req_adapter.sv
// tb/tb_sram_req_adapter.sv - randomized self-checking bench for sram_req_adapter
module tb_sram_req_adapter;

  localparam int AW = 8;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [BW-1:0] req_be = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [IW-1:0] req_id = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [IW-1:0] rsp_id;
  logic          init_done;
  logic          sram_cs;
  logic          sram_we;
  logic [BW-1:0] sram_ben;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  sram_req_adapter dut (
    .Clk_CI        (clk),
    .Rst_RI        (rst),
    .ReqValid_SI   (req_valid),
    .ReqReady_SO   (req_ready),
    .ReqWe_SI      (req_we),
    .ReqBe_SI      (req_be),
    .ReqAddr_DI    (req_addr),
    .ReqWdata_DI   (req_wdata),
    .ReqId_DI      (req_id),
    .RspValid_SO   (rsp_valid),
    .RspReady_SI   (rsp_ready),
    .RspRdata_DO   (rsp_rdata),
    .RspId_DO      (rsp_id),
    .InitDone_SO   (init_done),
    .SramCSel_SO   (sram_cs),
    .SramWrEn_SO   (sram_we),
    .SramBEn_SO    (sram_ben),
    .SramAddr_DO   (sram_addr),
    .SramWrData_DO (sram_wdata),
    .SramRdData_DI (sram_rdata)
  );

  always #5 clk = ~clk;

  // Physical SRAM in the environment: active-low byte mask, read data one cycle later.
  logic [DW-1:0] sram_mem [256];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (!sram_ben[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference model: word memory plus the queue of responses still owed.
  logic [DW-1:0]    ref_mem [256];
  logic [DW+IW-1:0] exp_q [$];
  logic [DW+IW-1:0] exp_e;

  int n_cmp = 0;
  int n_err = 0;

  logic          s_acc, s_cs, s_we, s_rdy, s_rv, s_done, s_pop;
  logic [BW-1:0] s_ben;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wd, s_rdata;
  logic [IW-1:0] s_rid;

  // One clock: snapshot outputs at the falling edge, update the model, then advance.
  task automatic tick();
    @(negedge clk);
    s_acc  = req_valid && req_ready;
    s_cs   = sram_cs;   s_we = sram_we;  s_ben = sram_ben;
    s_addr = sram_addr; s_wd = sram_wdata;
    s_rdy  = req_ready; s_rv = rsp_valid; s_done = init_done;
    s_rdata = rsp_rdata; s_rid = rsp_id;
    s_pop  = rsp_valid && rsp_ready;
    if (s_acc) begin
      if (req_we) begin
        for (int b = 0; b < BW; b++)
          if (req_be[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
      end else begin
        exp_q.push_back({ref_mem[req_addr], req_id});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({s_cs, s_rdy, s_rv, s_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: got cs/rdy/rv/done=%b expected 0000", {s_cs, s_rdy, s_rv, s_done});
    end
    n_cmp++;
    if ({s_rdata, s_rid} !== '0) begin
      n_err++;
      $display("FAIL reset_rsp: got %h/%h expected 0/0", s_rdata, s_rid);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_init();
    int bad;
    req_valid = 1'b1;
    req_we = 1'b0;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      n_cmp++;
      if (s_rdy !== 1'b0 || s_done !== 1'b0 || s_cs !== 1'b1 || s_we !== 1'b1 ||
          s_ben !== 8'h00 || s_addr !== AW'(i) || s_wd !== '0 || s_acc !== 1'b0) begin
        n_err++;
        if (bad < 4)
          $display("FAIL init_cycle_%0d: got rdy=%b done=%b cs=%b we=%b ben=%h addr=%h wd=%h expected 0 0 1 1 00 %h 0",
                   i, s_rdy, s_done, s_cs, s_we, s_ben, s_addr, s_wd, AW'(i));
        bad++;
      end
    end
    req_valid = 1'b0;
    tick();
    n_cmp++;
    if (s_done !== 1'b1 || s_rdy !== 1'b1 || s_cs !== 1'b0) begin
      n_err++;
      $display("FAIL init_done: got done=%b rdy=%b cs=%b expected 1 1 0", s_done, s_rdy, s_cs);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_be = 8'hFF;
    req_addr = 8'h10; req_wdata = 64'h0123456789ABCDEF; req_id = 4'h0;
    tick();
    n_cmp++;
    if (!s_acc || s_cs !== 1'b1 || s_we !== 1'b1 || s_ben !== 8'h00 ||
        s_addr !== 8'h10 || s_wd !== 64'h0123456789ABCDEF) begin
      n_err++;
      $display("FAIL wr_drive: got acc=%b cs=%b we=%b ben=%h addr=%h wd=%h expected 1 1 1 00 10 0123456789abcdef",
               s_acc, s_cs, s_we, s_ben, s_addr, s_wd);
    end
    req_we = 1'b0; req_id = 4'h5; req_wdata = '0;
    tick();
    n_cmp++;
    if (!s_acc || s_cs !== 1'b1 || s_we !== 1'b0 || s_addr !== 8'h10) begin
      n_err++;
      $display("FAIL rd_drive: got acc=%b cs=%b we=%b addr=%h expected 1 1 0 10", s_acc, s_cs, s_we, s_addr);
    end
    req_valid = 1'b0;
    tick();
    n_cmp++;
    if (s_rv !== 1'b0 || s_cs !== 1'b0) begin
      n_err++;
      $display("FAIL rd_lat_n1: got rv=%b cs=%b expected 0 0", s_rv, s_cs);
    end
    tick();
    n_cmp++;
    if (s_rv !== 1'b1 || s_rdata !== 64'h0123456789ABCDEF || s_rid !== 4'h5) begin
      n_err++;
      $display("FAIL rd_rsp: got rv=%b data=%h id=%h expected 1 0123456789abcdef 5", s_rv, s_rdata, s_rid);
    end
    if (exp_q.size() > 0) exp_e = exp_q.pop_front();
    tick();
    n_cmp++;
    if (s_rv !== 1'b0) begin
      n_err++;
      $display("FAIL rd_rsp_gone: got rv=%b expected 0", s_rv);
    end
  endtask

  task automatic test_partial_write();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_be = 8'h0F;
    req_addr = 8'h20; req_wdata = '1;
    tick();
    n_cmp++;
    if (!s_acc || s_ben !== 8'hF0 || s_cs !== 1'b1) begin
      n_err++;
      $display("FAIL part_ben: got acc=%b ben=%h cs=%b expected 1 f0 1", s_acc, s_ben, s_cs);
    end
    req_be = 8'h00; req_wdata = 64'hDEADBEEFDEADBEEF;
    tick();
    n_cmp++;
    if (!s_acc || s_cs !== 1'b1 || s_we !== 1'b1 || s_ben !== 8'hFF) begin
      n_err++;
      $display("FAIL zero_be: got acc=%b cs=%b we=%b ben=%h expected 1 1 1 ff", s_acc, s_cs, s_we, s_ben);
    end
    req_we = 1'b0; req_id = 4'hA;
    tick();
    req_valid = 1'b0;
    tick();
    n_cmp++;
    if (s_rv !== 1'b0) begin
      n_err++;
      $display("FAIL wr_no_rsp: got rv=%b expected 0", s_rv);
    end
    tick();
    n_cmp++;
    if (s_rv !== 1'b1 || s_rdata !== 64'h00000000FFFFFFFF || s_rid !== 4'hA) begin
      n_err++;
      $display("FAIL part_read: got rv=%b data=%h id=%h expected 1 00000000ffffffff a", s_rv, s_rdata, s_rid);
    end
    if (exp_q.size() > 0) exp_e = exp_q.pop_front();
    tick();
  endtask

  task automatic test_backpressure();
    int acc_n;
    int rsp_n;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      req_addr = AW'($urandom_range(0, 255));
      req_id = IW'(i + 3);
      tick();
      if (s_acc) acc_n++;
    end
    n_cmp++;
    if (acc_n != 3 || s_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accepts: got %0d accepts rdy=%b expected 3 accepts rdy=0", acc_n, s_rdy);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    rsp_n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_pop) begin
        rsp_n++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bp_rsp: got unexpected %h/%h expected none", s_rdata, s_rid);
        end else begin
          exp_e = exp_q.pop_front();
          if ({s_rdata, s_rid} !== exp_e) begin
            n_err++;
            $display("FAIL bp_rsp: got %h/%h expected %h/%h", s_rdata, s_rid, exp_e[DW+IW-1:IW], exp_e[IW-1:0]);
          end
        end
      end
    end
    n_cmp++;
    if (rsp_n != 3 || s_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL bp_drain: got %0d responses rdy=%b expected 3 responses rdy=1", rsp_n, s_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int acc_n;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 110; i++) begin
      if (i == 100) req_valid = 1'b0;
      req_addr = AW'($urandom_range(0, 255));
      req_id = IW'($urandom);
      tick();
      if (s_acc) acc_n++;
      if (s_pop) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_rsp: got unexpected %h/%h expected none", s_rdata, s_rid);
        end else begin
          exp_e = exp_q.pop_front();
          if ({s_rdata, s_rid} !== exp_e) begin
            n_err++;
            $display("FAIL b2b_rsp: got %h/%h expected %h/%h", s_rdata, s_rid, exp_e[DW+IW-1:IW], exp_e[IW-1:0]);
          end
        end
      end
      if (i == 99) begin
        n_cmp++;
        if (acc_n != 100) begin
          n_err++;
          $display("FAIL b2b_rate: got %0d accepts in 100 cycles expected 100", acc_n);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_left: got %0d responses outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 420; i++) begin
      if (i < 400) begin
        req_valid = ($urandom_range(0, 9) < 7);
        req_we = ($urandom_range(0, 9) < 4);
        req_be = BW'($urandom);
        req_addr = AW'($urandom_range(0, 15));
        req_wdata = {$urandom, $urandom};
        req_id = IW'($urandom);
        rsp_ready = ($urandom_range(0, 9) < 6);
      end else begin
        req_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      tick();
      if (s_acc && (s_cs !== 1'b1 || s_addr !== req_addr)) begin
        n_cmp++;
        n_err++;
        $display("FAIL rnd_drive: got cs=%b addr=%h expected 1 %h", s_cs, s_addr, req_addr);
      end
      if (s_pop) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_rsp: got unexpected %h/%h expected none", s_rdata, s_rid);
        end else begin
          exp_e = exp_q.pop_front();
          if ({s_rdata, s_rid} !== exp_e) begin
            n_err++;
            $display("FAIL rnd_rsp: got %h/%h expected %h/%h", s_rdata, s_rid, exp_e[DW+IW-1:IW], exp_e[IW-1:0]);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rnd_left: got %0d responses outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0;
    req_addr = 8'h10; req_id = 4'h1;
    tick();
    req_id = 4'h2;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (s_rv !== 1'b1) begin
      n_err++;
      $display("FAIL mid_queued: got rv=%b expected 1", s_rv);
    end
    rst = 1'b1;
    rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if (s_rv !== 1'b0 || s_cs !== 1'b0 || s_rdy !== 1'b0 || s_pop !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst: got rv=%b cs=%b rdy=%b expected 0 0 0", s_rv, s_cs, s_rdy);
    end
    exp_q.delete();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (s_cs !== 1'b1 || s_we !== 1'b1 || s_addr !== 8'h00 || s_rv !== 1'b0 || s_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_init0: got cs=%b we=%b addr=%h rv=%b rdy=%b expected 1 1 00 0 0",
               s_cs, s_we, s_addr, s_rv, s_rdy);
    end
    for (int i = 1; i < 256; i++) tick();
    n_cmp++;
    if (s_addr !== 8'hFF || s_done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_init255: got addr=%h done=%b expected ff 0", s_addr, s_done);
    end
    tick();
    n_cmp++;
    if (s_done !== 1'b1 || s_rv !== 1'b0) begin
      n_err++;
      $display("FAIL mid_done: got done=%b rv=%b expected 1 0", s_done, s_rv);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = {$urandom, $urandom};
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    test_reset();
    test_init();
    test_write_read();
    test_partial_write();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
